// File: rtl/bcd_value_converter_if.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_value_converter_if
//  Purpose  : Start/result bundle between a requester and bcd_value_converter.
//  Revision : 1.0  initial release
// ============================================================================
interface bcd_value_converter_if #(
    parameter int IN_W = 16
);
    logic            start_i;
    logic [IN_W-1:0] bin_i;
    logic            busy_o;
    logic            done_o;
    logic            ovf_o;
    logic [15:0]     ss__value_o;

    modport master (
        output start_i, bin_i,
        input  busy_o, done_o, ovf_o, ss__value_o
    );

    modport slave (
        input  start_i, bin_i,
        output busy_o, done_o, ovf_o, ss__value_o
    );
endinterface
`default_nettype wire

// File: rtl/bcd_value_converter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_value_converter
//  Purpose  : Iterative double-dabble binary to 4-digit packed BCD converter.
//             Define BCD_SATURATE_EN to show 9999 on overflow instead of EEEE.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_value_converter #(
    parameter int IN_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    bcd_value_converter_if.slave  bus
);
    localparam int CNT_W = $clog2(IN_W + 1);
`ifdef BCD_SATURATE_EN
    localparam logic [15:0] C_OVF_PATTERN = 16'h9999;
`else
    localparam logic [15:0] C_OVF_PATTERN = 16'hEEEE;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   shreg_q, shreg_d;
    logic [15:0]       scratch_q, scratch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_ovf_q, pend_ovf_d;
    logic [15:0]       value_q, value_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [15:0]       w_adj;

    // Add-3 correction per nibble, no carry between digits.
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
        assign w_adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                ? scratch_q[4*gi +: 4] + 4'd3
                                : scratch_q[4*gi +: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            pend_ovf_q <= 1'b0;
            value_q    <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            pend_ovf_q <= pend_ovf_d;
            value_q    <= value_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        pend_ovf_d = pend_ovf_q;
        value_d    = value_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    shreg_d    = bus.bin_i;
                    scratch_d  = '0;
                    cnt_d      = CNT_W'(IN_W);
                    pend_ovf_d = (32'(bus.bin_i) > 32'd9999);
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {scratch_d, shreg_d} = {w_adj, shreg_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                value_d = pend_ovf_q ? C_OVF_PATTERN : scratch_q;
                ovf_d   = pend_ovf_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.ovf_o       = ovf_q;
    assign bus.ss__value_o = value_q;
endmodule
`default_nettype wire

// File: doc/bcd_value_converter.md
# bcd_value_converter

Sequential binary-to-BCD converter that produces the 16-bit `ss__value` word consumed by the four-digit seven-segment display controller. It accepts an unsigned binary value on a start strobe, runs an iterative shift-and-add-3 (double-dabble) conversion, and registers four packed BCD digits so the display shows decimal rather than hex. Inputs above 9999 are flagged as overflow and replaced by a fixed pattern.

## Interface
- `IN_W`, default 16: binary input width; legal range 4..16.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset; **asynchronous, active-high**. One clock, `clk`; no other clock domain.
- `start`  in  1  conversion request; sampled on rising edge; honoured only in IDLE.
- `bin`  in  IN_W  unsigned value; captured on the edge that accepts `start`; ignored otherwise.
- `busy`  out  1  high while state is not IDLE.
- `done`  out  1  one-cycle pulse; `ss__value` and `ovf` are valid and updated.
- `ovf`  out  1  last completed conversion had `bin` > 9999; held until next completion.
- `ss__value`  out  16  packed BCD, digit 3 (thousands) in [15:12] down to units in [3:0]; held between completions.

## Operation
- States: IDLE, SHIFT, LOAD.
- IDLE: `start`=1 → capture `bin` into shift register, clear the 16-bit BCD scratch, load shift counter with IN_W, record `bin > 9999` into a pending-overflow bit, go SHIFT. `start`=0 → stay.
- SHIFT, one bit per cycle: each scratch nibble ≥ 5 gets +3 (all four nibbles in parallel, 4-bit add, no carry between nibbles), then the {scratch, shift register} concatenation shifts left by 1, MSB of `bin` entering scratch bit 0. Decrement counter; after the IN_W-th shift go LOAD.
- LOAD: pending-overflow = 0 → `ss__value` ← scratch, `ovf` ← 0. Pending-overflow = 1 → `ss__value` ← overflow pattern (see Configuration), `ovf` ← 1. Assert `done` for the following cycle; go IDLE.
- Bits shifted out of scratch [15] are discarded; only reachable on overflow, which is overridden.
- `start` while `busy` is ignored: no queueing, no error, and `bin` is not re-captured.
- `start` in the cycle where `done` is high is accepted (state is IDLE).
- Reset asserted at any time, including mid-SHIFT: immediately forces IDLE and aborts the conversion. `ss__value`=16'h0000, `ovf`=0, `busy`=0, `done`=0, scratch, shift register and counter cleared. A conversion in flight produces no `done`.

## Timing
- `start` accepted at edge E0 → SHIFT occupies edges E1..E(IN_W) → LOAD updates `ss__value`/`ovf` at edge E(IN_W+1), with `done` high in the cycle after it.
- IN_W=16: result at edge 17; `busy` high for 17 cycles (after E0 through E16), low after E17.
- `done` is exactly one cycle wide. It coincides with `busy`=0.
- Maximum throughput: one conversion per IN_W+1 cycles.
- All outputs are registered; no combinational path from `start` or `bin` to any output.
- `ss__value` changes only at LOAD or reset, never glitches mid-conversion, so the display scan never shows partial digits.

## Configuration
- `BCD_SATURATE_EN` defined: overflow pattern = 16'h9999 (display saturates at 9999).
- `BCD_SATURATE_EN` undefined: overflow pattern = 16'hEEEE (display shows "EEEE").
- `ovf` behaviour is identical either way.

## Test plan
- Reset, then `bin`=16'd1234 with `start` pulsed one cycle → `ss__value`=16'h1234, `ovf`=0, `done` high exactly one cycle after edge 17, `busy` high for 17 cycles.
- `bin`=0 → 16'h0000. `bin`=9999 → 16'h9999, `ovf`=0. `bin`=5 → 16'h0005. Back-to-back conversions, each `start` issued in the preceding `done` cycle, with no idle gap.
- `bin`=10000 → `ovf`=1; `ss__value`=16'h9999 with `BCD_SATURATE_EN` defined, 16'hEEEE without it. A following `bin`=42 conversion clears `ovf` and gives 16'h0042.
- `start` with `bin`=1111, then `start` with `bin`=2222 at edge 5 → result 16'h1111 and only one `done` pulse.
- Complete `bin`=4321, then start `bin`=8765 and assert `rst` at edge 8 → all outputs at reset values immediately, with no `done`. After release, `bin`=8765 gives 16'h8765.
- IN_W=8, `bin`=8'd255 → 16'h0255 at edge 9.
